hub75_row_capture: RTL

Receive-side counterpart of the HUB75 panel driver. It samples the serial panel interface on the system clock and rebuilds each latched upper/lower row pair into parallel 64-bit RGB vectors. Captured rows are presented on a valid/ready port, together with the panel address and the measured unblank time. It is used in FPGA loopback and bench builds to check the driver's shift/latch/blank sequencing without a physical panel.

---
 rtl/hub75_pkg.sv | 13 +
 rtl/hub75_row_capture_if.sv | 31 +++
 rtl/hub75_sync_edge.sv | 32 +++
 rtl/hub75_row_capture.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared defaults and capture FSM state type for the HUB75 row capture block.
package hub75_pkg;

    localparam int COLS_DEF   = 64;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_SHIFT,
        CAP_COMMIT
    } CapState;

endpackage

// File: rtl/hub75_row_capture_if.sv
// Captured-row output port: parallel RGB row plus address and on-time, valid/ready.
interface hub75_row_capture_if #(
    parameter int COLS   = 64,
    parameter int ADDR_W = 5,
    parameter int ON_W   = 16
);

    logic              row_valid;
    logic              row_ready;
    logic [COLS-1:0]   row_r0;
    logic [COLS-1:0]   row_g0;
    logic [COLS-1:0]   row_b0;
    logic [COLS-1:0]   row_r1;
    logic [COLS-1:0]   row_g1;
    logic [COLS-1:0]   row_b1;
    logic [ADDR_W-1:0] row_addr;
    logic [ON_W-1:0]   row_on_cycles;

    modport master (
        output row_valid, row_r0, row_g0, row_b0, row_r1, row_g1, row_b1,
               row_addr, row_on_cycles,
        input  row_ready
    );

    modport slave (
        input  row_valid, row_r0, row_g0, row_b0, row_r1, row_g1, row_b1,
               row_addr, row_on_cycles,
        output row_ready
    );

endinterface

// File: rtl/hub75_sync_edge.sv
// Two-flop synchronizer with one extra stage for rise/fall detection.
module hub75_sync_edge #(
    parameter int           W    = 1,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] s1, s2, s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= INIT;
            s2 <= INIT;
            s3 <= INIT;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/hub75_row_capture.sv
// Samples the serial HUB75 panel interface and rebuilds each latched row pair
// into parallel RGB vectors with address, unblank time and sequencing errors.
module hub75_row_capture
    import hub75_pkg::*;
#(
    parameter int COLS        = COLS_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int ON_W        = 16,
    parameter int SAMPLE_FALL = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0,
    input  logic              g0,
    input  logic              b0,
    input  logic              r1,
    input  logic              g1,
    input  logic              b1,
    input  logic              sck,
    input  logic              latch,
    input  logic              blank,
    input  logic [ADDR_W-1:0] addr,
    input  logic              clear,
    output logic              err_len,
    output logic              err_ovf,
    output logic [7:0]        err_count,
    hub75_row_capture_if.master row
);

    function automatic logic [6:0] sat_inc7(input logic [6:0] v);
        return (v == '1) ? v : v + 7'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == '1) ? v : v + 8'd1;
    endfunction

    function automatic logic [ON_W-1:0] sat_inc_on(input logic [ON_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [5:0]        din_s1, din_s2;
    logic [ADDR_W-1:0] addr_s1, addr_s2;
    logic sck_sync, sck_rise, sck_fall;
    logic latch_sync, latch_rise, latch_fall;
    logic blank_sync, blank_rise, blank_fall;

    // Data and address get the same two-flop depth as the control syncs so
    // the bit seen next to a detected sck edge is the one launched with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_s1  <= '0;
            din_s2  <= '0;
            addr_s1 <= '0;
            addr_s2 <= '0;
        end else begin
            din_s1  <= {r0, g0, b0, r1, g1, b1};
            din_s2  <= din_s1;
            addr_s1 <= addr;
            addr_s2 <= addr_s1;
        end
    end

    hub75_sync_edge #(.W(1)) u_sck_sync (
        .clk(clk), .reset(reset), .din(sck),
        .sync(sck_sync), .rise(sck_rise), .fall(sck_fall)
    );

    hub75_sync_edge #(.W(1)) u_latch_sync (
        .clk(clk), .reset(reset), .din(latch),
        .sync(latch_sync), .rise(latch_rise), .fall(latch_fall)
    );

    hub75_sync_edge #(.W(1), .INIT(1'b1)) u_blank_sync (
        .clk(clk), .reset(reset), .din(blank),
        .sync(blank_sync), .rise(blank_rise), .fall(blank_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_sync, latch_sync, latch_fall, blank_rise, blank_fall};

    CapState state, state_nxt;
    logic sck_edge, shift_en, defer_vld, commit_ok, commit_bad;
    logic [5:0] defer_d, shift_d;
    logic [6:0] bit_cnt;
    logic [ON_W-1:0] on_cnt;
    logic [COLS-1:0] sr [6];

    // An sck edge coinciding with the latch edge belongs to the next row: it is
    // held back one cycle and applied in the commit cycle after the count check.
    assign sck_edge   = (SAMPLE_FALL != 0) ? sck_fall : sck_rise;
    assign shift_en   = defer_vld | (sck_edge & ~latch_rise);
    assign shift_d    = defer_vld ? defer_d : din_s2;
    assign commit_ok  = (state == CAP_COMMIT) && (bit_cnt == 7'(COLS));
    assign commit_bad = (state == CAP_COMMIT) && (bit_cnt != 7'(COLS));

    always_ff @(posedge clk) begin
        if (reset) state <= CAP_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CAP_IDLE: begin
                if (latch_rise)    state_nxt = CAP_COMMIT;
                else if (sck_edge) state_nxt = CAP_SHIFT;
            end
            CAP_SHIFT:  if (latch_rise) state_nxt = CAP_COMMIT;
            CAP_COMMIT: state_nxt = CAP_IDLE;
            default:    state_nxt = CAP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            defer_vld <= 1'b0;
            defer_d   <= '0;
            bit_cnt   <= '0;
            on_cnt    <= '0;
            for (int i = 0; i < 6; i++) sr[i] <= '0;
        end else begin
            defer_vld <= latch_rise & sck_edge;
            defer_d   <= din_s2;
            if (shift_en)
                for (int i = 0; i < 6; i++) sr[i] <= {shift_d[i], sr[i][COLS-1:1]};
            if (state == CAP_COMMIT) begin
                bit_cnt <= shift_en ? 7'd1 : 7'd0;
                on_cnt  <= '0;
            end else begin
                if (shift_en)    bit_cnt <= sat_inc7(bit_cnt);
                if (!blank_sync) on_cnt  <= sat_inc_on(on_cnt);
            end
        end
    end

    // Output port and sticky error flags; an error in the same cycle as clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            row.row_valid     <= 1'b0;
            row.row_r0        <= '0;
            row.row_g0        <= '0;
            row.row_b0        <= '0;
            row.row_r1        <= '0;
            row.row_g1        <= '0;
            row.row_b1        <= '0;
            row.row_addr      <= '0;
            row.row_on_cycles <= '0;
            err_len           <= 1'b0;
            err_ovf           <= 1'b0;
            err_count         <= '0;
        end else begin
            if (commit_ok) begin
                row.row_valid     <= 1'b1;
                row.row_r0        <= sr[5];
                row.row_g0        <= sr[4];
                row.row_b0        <= sr[3];
                row.row_r1        <= sr[2];
                row.row_g1        <= sr[1];
                row.row_b1        <= sr[0];
                row.row_addr      <= addr_s2;
                row.row_on_cycles <= on_cnt;
            end else if (row.row_valid && row.row_ready) begin
                row.row_valid <= 1'b0;
            end

            if (commit_ok && row.row_valid && !row.row_ready) err_ovf <= 1'b1;
            else if (clear)                                   err_ovf <= 1'b0;

            if (commit_bad) begin
                err_len   <= 1'b1;
                err_count <= sat_inc8(err_count);
            end else if (clear) begin
                err_len   <= 1'b0;
                err_count <= '0;
            end
        end
    end

endmodule
